// File: rtl/vga_pkg.sv
// Shared VGA constants: grant encoding, bus width defaults and display timing.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package vga_pkg;

    // Default VRAM geometry: 640x480 pixels, one bit each of R, G and B.
    localparam int VGA_ADDR_W = 19;
    localparam int VGA_DATA_W = 3;

    // Visible area, shared with vga_sync.
    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    // Owner of the single VRAM port for the current cycle.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DISP = 2'd1;
    localparam logic [1:0] GNT_WR0  = 2'd2;
    localparam logic [1:0] GNT_WR1  = 2'd3;

    // Map a writer index (0/1) onto its grant code.
    function automatic logic [1:0] writer_gnt(input logic idx);
        return idx ? GNT_WR1 : GNT_WR0;
    endfunction

endpackage

// File: rtl/vga_rr_pick2.sv
// Two-requester round-robin picker; the pointer starts at requester 0.
// Latency: pick is combinational, the pointer moves on the edge that takes the pick.
// Backpressure: a masked requester is invisible; the pointer only moves when advance is high.
module vga_rr_pick2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] mask,
    input  logic       advance,
    output logic       vld,
    output logic       sel,
    output logic       rr
);

    logic rr_q;
    logic elig0;
    logic elig1;

    // Eligible requesters and the pick: the pointer only breaks ties.
    always_comb begin
        elig0 = req0 & ~mask[0];
        elig1 = req1 & ~mask[1];
        vld   = elig0 | elig1;
        if (elig0 && elig1) begin
            sel = rr_q;
        end else begin
            sel = elig1;
        end
        rr = rr_q;
    end

    // After a writer is served the pointer favours the other writer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (advance && vld) begin
            rr_q <= ~sel;
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has fixed priority, two writers share the rest round-robin.
// Latency: write ack during the cycle after the request is sampled; display data valid two edges after the command edge.
// Backpressure: writers hold req until ack; reads are never stalled. Macro VGA_VRAM_ARB_BLANK_ONLY_EN restricts writes to blanking.
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W = VGA_ADDR_W,
    parameter int DATA_W = VGA_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ack,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [1:0]        gnt_q;
    logic [1:0]        gnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic              rd_pend_q;
    logic              blank_block;
    logic [1:0]        wr_mask;
    logic              pick_vld;
    logic              pick_sel;
    logic              pick_rr;
    logic              pick_unused;

`ifdef VGA_VRAM_ARB_BLANK_ONLY_EN
    // Writers only see the port while the beam is blanked, so a shown frame never tears.
    assign blank_block = video_on;
`else
    // Writers may take any slot the display leaves free; video_on is not needed.
    assign blank_block = 1'b0 & video_on;
`endif

    // The pointer is only observed inside the picker.
    assign pick_unused = pick_rr;

    // A writer whose ack is on the port this cycle still has req high; hide it so it is not granted twice.
    always_comb begin
        wr_mask[0] = (gnt_q == GNT_WR0) | blank_block;
        wr_mask[1] = (gnt_q == GNT_WR1) | blank_block;
    end

    vga_rr_pick2 u_pick (
        .clk     (clk),
        .reset   (reset),
        .req0    (wr0_req),
        .req1    (wr1_req),
        .mask    (wr_mask),
        .advance (!disp_req),
        .vld     (pick_vld),
        .sel     (pick_sel),
        .rr      (pick_rr)
    );

    // Next grant: display strobe first, then the picked writer, otherwise idle.
    always_comb begin
        gnt_d   = GNT_NONE;
        addr_d  = '0;
        wdata_d = '0;
        if (disp_req) begin
            gnt_d  = GNT_DISP;
            addr_d = disp_addr;
        end else if (pick_vld) begin
            gnt_d   = writer_gnt(pick_sel);
            addr_d  = pick_sel ? wr1_addr : wr0_addr;
            wdata_d = pick_sel ? wr1_data : wr0_data;
        end
    end

    // Grant register; the command address/data are captured with it so the display strobe need not be held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q   <= GNT_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // RAM command and acks decode straight from the grant, so reset drops them without waiting for an edge.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        wr0_ack   = 1'b0;
        wr1_ack   = 1'b0;
        case (gnt_q)
            GNT_DISP: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
            end
            GNT_WR0: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                wr0_ack   = 1'b1;
            end
            GNT_WR1: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                wr1_ack   = 1'b1;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // Read return: the RAM answers one cycle after the command, captured here with a single-cycle valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_pend_q  <= (gnt_q == GNT_DISP);
            disp_valid <= rd_pend_q;
            if (rd_pend_q) begin
                disp_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 3;
    localparam int M_NONE = 0;
    localparam int M_DISP = 1;
    localparam int M_WR0  = 2;
    localparam int M_WR1  = 3;

    logic          clk;
    logic          reset;
    logic          video_on;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wr0_req;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr0_ack;
    logic          wr1_req;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;
    logic          wr1_ack;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    vga_vram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr0_req    (wr0_req),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_ack    (wr0_ack),
        .wr1_req    (wr1_req),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_ack    (wr1_ack),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port VRAM stand-in.
    logic [DW-1:0] ram_mem [int];
    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[int'(ram_addr)] = ram_wdata;
            end else begin
                ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
            end
        end
    end

    // Protocol monitor: a writer must keep req high until it has seen its ack.
    logic p_req0 = 1'b0, p_ack0 = 1'b0, p_req1 = 1'b0, p_ack1 = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            p_req0 <= 1'b0; p_ack0 <= 1'b0; p_req1 <= 1'b0; p_ack1 <= 1'b0;
        end else begin
            if (p_req0 && !p_ack0) assert (wr0_req) else $error("FAIL wr0_req dropped before ack");
            if (p_req1 && !p_ack1) assert (wr1_req) else $error("FAIL wr1_req dropped before ack");
            p_req0 <= wr0_req; p_ack0 <= wr0_ack;
            p_req1 <= wr1_req; p_ack1 <= wr1_ack;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port this cycle, what it carries, and the frame contents.
    int            m_gnt;
    int            m_rr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            p1_vld;
    logic [DW-1:0] p1_dat;
    logic [DW-1:0] o_dat;
    bit            o_vld;
    int            wcnt0, wcnt1;
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return '0;
    endfunction

    task automatic model_reset();
        m_gnt = M_NONE; m_rr = 0; m_addr = '0; m_wdata = '0;
        p1_vld = 0; p1_dat = '0; o_vld = 0; o_dat = '0;
        wcnt0 = 0; wcnt1 = 0;
    endtask

    task automatic check_outputs();
        bit exp_en, exp_we;
        exp_en = (m_gnt != M_NONE);
        exp_we = (m_gnt == M_WR0) || (m_gnt == M_WR1);
        chk("ram_en", ram_en, exp_en);
        chk("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, exp_en ? m_addr : '0);
        chk("ram_wdata", ram_wdata, exp_we ? m_wdata : '0);
        chk("wr0_ack", wr0_ack, m_gnt == M_WR0);
        chk("wr1_ack", wr1_ack, m_gnt == M_WR1);
        chk("disp_valid", disp_valid, o_vld);
        chk("disp_data", disp_data, o_dat);
    endtask

    // One clock: decide the grant from the rules, advance the model, compare just after the edge.
    task automatic step();
        bit            e0, e1, blank_ok;
        int            nx, k;
        logic [AW-1:0] na;
        logic [DW-1:0] nd;
        blank_ok = 1;
`ifdef VGA_VRAM_ARB_BLANK_ONLY_EN
        blank_ok = !video_on;
`endif
        e0 = wr0_req && (m_gnt != M_WR0) && blank_ok;
        e1 = wr1_req && (m_gnt != M_WR1) && blank_ok;
        nx = M_NONE; na = '0; nd = '0; k = 0;
        if (disp_req) begin
            nx = M_DISP; na = disp_addr;
        end else if (e0 || e1) begin
            k  = (e0 && e1) ? m_rr : (e1 ? 1 : 0);
            nx = k ? M_WR1 : M_WR0;
            na = k ? wr1_addr : wr0_addr;
            nd = k ? wr1_data : wr0_data;
        end
        if (wr0_req && m_gnt != M_WR0) wcnt0++;
        if (wr1_req && m_gnt != M_WR1) wcnt1++;
        @(posedge clk);
        o_vld = p1_vld;
        if (p1_vld) o_dat = p1_dat;
        p1_vld = (m_gnt == M_DISP);
        if (p1_vld) p1_dat = ref_rd(int'(m_addr));
        if (m_gnt == M_WR0 || m_gnt == M_WR1) ref_mem[int'(m_addr)] = m_wdata;
        if (nx == M_WR0 || nx == M_WR1) begin
`ifndef VGA_VRAM_ARB_BLANK_ONLY_EN
            chk("wr_wait_le4", ((k ? wcnt1 : wcnt0) <= 4), 1);
`endif
            if (k) wcnt1 = 0; else wcnt0 = 0;
            m_rr = k ? 0 : 1;
        end
        m_gnt = nx; m_addr = na; m_wdata = nd;
        #1;
        check_outputs();
    endtask

    initial begin
        int  n;
        bit  got, prev0, was0, was1, last_disp;
        reset = 1'b1; video_on = 1'b0; disp_req = 1'b0; disp_addr = '0;
        wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_wr0_ack", wr0_ack, 0);
        chk("rst_wr1_ack", wr1_ack, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data", disp_data, 0);
        reset = 1'b0;

        // Reset in the middle of a write, then re-grant with wr0 first.
        wr0_req = 1'b1; wr0_addr = 19'd5; wr0_data = 3'd6;
        step();
        chk("midrst_ack_before", wr0_ack, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_wr0_ack", wr0_ack, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        #2 reset = 1'b0;
        model_reset();
        wr1_req = 1'b1; wr1_addr = 19'd6; wr1_data = 3'd7;
        step();
        chk("midrst_regrant_wr0", wr0_ack, 1);
        step();
        chk("midrst_then_wr1", wr1_ack, 1);
        wr0_req = 1'b0;
        step();
        wr1_req = 1'b0;

        // Display fetch from a preloaded location.
        ram_mem[32'h12345] = 3'b101;
        ref_mem[32'h12345] = 3'b101;
        disp_req = 1'b1; disp_addr = 19'h12345;
        step();
        disp_req = 1'b0;
        n = 1; got = 0;
        chk("rd_we_low", ram_we, 0);
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            n++;
            chk("rd_we_low", ram_we, 0);
            if (disp_valid) got = 1;
        end
        chk("rd_latency", n, 3);
        chk("rd_data", disp_data, 3'b101);
        step();
        chk("rd_valid_one_cycle", disp_valid, 0);

        // Both writers held: strict alternation starting with wr0.
        wr0_req = 1'b1; wr0_addr = 19'd20; wr0_data = 3'd1;
        wr1_req = 1'b1; wr1_addr = 19'd21; wr1_data = 3'd2;
        prev0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("alt_one_hot", wr0_ack ^ wr1_ack, 1);
            if (i == 0) chk("alt_first_wr0", wr0_ack, 1);
            else        chk("alt_toggle", wr0_ack, !prev0);
            prev0 = wr0_ack;
        end
        if (wr0_ack) begin
            wr1_req = 1'b0; step(); wr0_req = 1'b0;
        end else begin
            wr0_req = 1'b0; step(); wr1_req = 1'b0;
        end

        // Display every other cycle; wr1 fills a free slot.
        wr1_req = 1'b1; wr1_addr = 19'h00010; wr1_data = 3'b011;
        disp_addr = 19'd40;
        n = 0; got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            disp_req = (i % 2 == 0);
            step();
            n++;
            if (wr1_ack) got = 1;
        end
        chk("wr1_slot_within2", got && (n <= 2), 1);
        disp_req = 1'b0;
        step();
        wr1_req = 1'b0;
        disp_req = 1'b1; disp_addr = 19'h00010;
        step();
        disp_req = 1'b0;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            step();
            if (disp_valid) got = 1;
        end
        chk("wr1_readback_seen", got, 1);
        chk("wr1_readback", disp_data, 3'b011);

        // All three at once with the pointer on wr1.
        wr0_req = 1'b1; wr0_addr = 19'd7; wr0_data = 3'd4;
        step();
        step();
        wr0_req = 1'b0;
        step();
        disp_req = 1'b1; disp_addr = 19'd9;
        wr0_req = 1'b1; wr0_addr = 19'd8; wr0_data = 3'd5;
        wr1_req = 1'b1; wr1_addr = 19'd11; wr1_data = 3'd6;
        step();
        chk("sim_first_disp", ram_en && !ram_we, 1);
        disp_req = 1'b0;
        step();
        chk("sim_second_wr1", wr1_ack, 1);
        step();
        chk("sim_third_wr0", wr0_ack, 1);
        wr1_req = 1'b0;
        step();
        wr0_req = 1'b0;
        step();

`ifdef VGA_VRAM_ARB_BLANK_ONLY_EN
        // Writes wait for blanking.
        video_on = 1'b1;
        wr0_req = 1'b1; wr0_addr = 19'd3; wr0_data = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("blank_no_ack", wr0_ack, 0);
        end
        video_on = 1'b0;
        step();
        chk("blank_ack_after", wr0_ack, 1);
        step();
        wr0_req = 1'b0;
        step();
`endif

        // Randomized traffic against the model.
        was0 = 0; was1 = 0; last_disp = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (was0 || !wr0_req) begin
                wr0_req  = ($urandom_range(0, 2) != 0);
                wr0_addr = AW'($urandom_range(0, 31));
                wr0_data = DW'($urandom);
            end
            if (was1 || !wr1_req) begin
                wr1_req  = ($urandom_range(0, 2) != 0);
                wr1_addr = AW'($urandom_range(0, 31));
                wr1_data = DW'($urandom);
            end
            was0 = wr0_ack;
            was1 = wr1_ack;
            disp_req  = last_disp ? 1'b0 : ($urandom_range(0, 1) == 1);
            last_disp = disp_req;
            disp_addr = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) video_on = ~video_on;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Single-port video-RAM arbiter between the VGA scan-out path and two pixel writers. The display fetch always wins. The two writers share the leftover RAM slots round-robin through a req/ack handshake. It sits between `vga_sync`/rgb output logic and the one synchronous-read VRAM, so drawing engines can update the frame while it is shown.

## Interface
- `ADDR_W`, default 19: VRAM address width (640×480 = 307200 pixels).
- `DATA_W`, default 3: pixel width, 1 bit each for R, G, B.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `video_on` input, 1 bit: active-video flag from `vga_sync`.
- `disp_req` input, 1 bit: one-cycle display fetch strobe, at most one every 2 cycles.
- `disp_addr` input, ADDR_W: display fetch address.
- `disp_data` output, DATA_W: fetched pixel.
- `disp_valid` output, 1 bit: one-cycle pulse, `disp_data` is valid.
- `wr0_req`, `wr1_req` inputs, 1 bit each: write request, held until ack.
- `wr0_addr`, `wr1_addr` inputs, ADDR_W each: write address, stable while req is high.
- `wr0_data`, `wr1_data` inputs, DATA_W each: write data, stable while req is high.
- `wr0_ack`, `wr1_ack` outputs, 1 bit each: one-cycle pulse, write committed.
- `ram_en` output, 1 bit: RAM port enable.
- `ram_we` output, 1 bit: RAM write enable.
- `ram_addr` output, ADDR_W: RAM address.
- `ram_wdata` output, DATA_W: RAM write data.
- `ram_rdata` input, DATA_W: RAM read data, valid 1 cycle after a read command.

## Operation
- Registered grant state `gnt_q` takes one of four values:
  - NONE: `ram_en`=0.
  - DISP: `ram_en`=1, `ram_we`=0, `ram_addr`=`disp_addr`.
  - WR0 / WR1: `ram_en`=1, `ram_we`=1, address and data from that writer.
- Each edge computes the next grant with fixed priority: `disp_req` beats writers, writers beat NONE.
- Writer selection between wr0 and wr1:
  - If both are eligible, pick the one indicated by round-robin pointer `rr_q`.
  - `rr_q` toggles to the other writer after every writer grant.
  - Reset value of `rr_q` is wr0.
- `wrN_ack` = (`gnt_q` == WRN), so the ack is high in the same cycle the write is on the RAM port.
- While `wrN_ack` is high, `wrN_req` is masked from arbitration. This prevents re-granting a request the writer has not yet dropped.
- A writer may present its next request in the cycle after ack.
- Read pipeline: `rd_pend_q` <= (`gnt_q` == DISP). When `rd_pend_q` is set, `disp_data` <= `ram_rdata` and `disp_valid` pulses for one cycle.
- Writer requests that arrive while the display is requesting wait; the pending request is not lost.
- All address and data paths are pass-through at full width, with no arithmetic.

## Timing
- Reset values: all outputs 0, `gnt_q`=NONE, `rr_q`=wr0, `rd_pend_q`=0.
- Reset mid-operation aborts any in-flight command immediately, because `ram_en` drops asynchronously.
- Display latency: `disp_req` sampled at edge E, then RAM command during E..E+1, then `disp_valid` high after edge E+2. The display path must prefetch 3 cycles ahead.
- Write latency with no contention: request sampled at E, ack high during E..E+1, data written at edge E+1.
- Display traffic takes at most 50% of slots, so each writer waits at most 4 cycles with the macro off.
- If `disp_req` and both writers request in the same cycle, order is DISP, then writer `rr_q`, then the other writer.
- Deasserting `wrN_req` before ack is illegal. Behaviour is undefined, and the bench flags it with an assertion.

## Configuration
- Macro `VGA_VRAM_ARB_BLANK_ONLY_EN`:
  - Defined: writers are eligible only when `video_on`=0, so writes never share the port during active video (tear-free updates). Writer wait is bounded by one line's active period (640 px).
  - Undefined: writers use any cycle not taken by the display.

## Structure
- Shared package `vga_pkg` holds:
  - the grant encoding constants `GNT_NONE`, `GNT_DISP`, `GNT_WR0`, `GNT_WR1` (2-bit);
  - the defaults `VGA_ADDR_W`=19 and `VGA_DATA_W`=3;
  - the `H_DISPLAY`/`V_DISPLAY` timing constants shared with `vga_sync`.
- One sub-module, `vga_rr_pick2`: a 2-requester round-robin picker, with pointer update and inputs req0/req1/mask.

## Test plan
- Reset mid-write (`wr0_req`=1, `gnt_q`=WR0, reset pulse) -> all outputs 0 at once, `rr_q`=wr0, and wr0 is re-granted after reset release.
- `disp_req` at addr 0x12345, RAM preloaded with 3'b101 -> `disp_valid` pulses exactly 3 edges later with `disp_data`=3'b101; `ram_we` stays 0 throughout.
- `wr0_req` and `wr1_req` held continuously, no display traffic -> acks alternate wr0, wr1, wr0, wr1, with each ack 1 cycle wide and never back-to-back for the same port.
- `disp_req` every 2nd cycle, `wr1_req` (addr 0x00010, data 3'b011) asserted -> `wr1_ack` arrives within 2 cycles in a non-display slot, and RAM location 0x10 then reads 3'b011.
- Simultaneous `disp_req`, `wr0_req` and `wr1_req` with `rr_q`=wr1 -> grant order DISP, WR1, WR0.
- With `VGA_VRAM_ARB_BLANK_ONLY_EN` defined, `wr0_req` raised while `video_on`=1 -> no ack until `video_on` falls, then `wr0_ack` in the first free cycle.
